// File: rtl/btb_pkg.sv
// rtl/btb_pkg.sv - shared entry type, counter constants and counter helper for the BTB
package btb_pkg;

    localparam int DEF_BTB_INDEX = 4;
    localparam int DEF_IDX_LSB   = 2;
    localparam int DEF_CTR_BITS  = 2;
    localparam int ENTRY_TAG_W   = 32 - DEF_IDX_LSB - DEF_BTB_INDEX;

    typedef struct packed {
        logic                    valid;
        logic [ENTRY_TAG_W-1:0]  tag;
        logic [29:0]             target;
        logic [DEF_CTR_BITS-1:0] ctr;
    } btb_entry_t;

    localparam logic [DEF_CTR_BITS-1:0] CTR_WEAK_TAKEN   = {1'b1, {(DEF_CTR_BITS-1){1'b0}}};
    localparam logic [DEF_CTR_BITS-1:0] CTR_STRONG_TAKEN = '1;

    function automatic logic [DEF_CTR_BITS-1:0] sat_ctr_next(
        input logic [DEF_CTR_BITS-1:0] ctr,
        input logic                    taken
    );
        if (taken) begin
            return (ctr == CTR_STRONG_TAKEN) ? ctr : ctr + DEF_CTR_BITS'(1);
        end
        return (ctr == '0) ? ctr : ctr - DEF_CTR_BITS'(1);
    endfunction

endpackage

// File: rtl/bpred_btb_plru_tree.sv
// rtl/bpred_btb_plru_tree.sv - tree-PLRU victim select and touch update for one BTB set
module plru_tree #(
    parameter  int WAYS = 2,
    localparam int PW   = (WAYS > 1) ? WAYS - 1 : 1,
    localparam int WW   = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic [PW-1:0] state_i,
    input  logic [WW-1:0] touch_i,
    output logic [WW-1:0] victim_o,
    output logic [PW-1:0] state_o
);

    // A tree bit of 0 points the victim search at its lower half; touching a way
    // points every bit on its path away from it. Outputs stay as separate assigns so
    // the victim never depends on the touch input.
    generate
        if (WAYS == 4) begin : g_four
            assign victim_o   = state_i[0] ? {1'b1, state_i[2]} : {1'b0, state_i[1]};
            assign state_o[0] = ~touch_i[1];
            assign state_o[1] = touch_i[1] ? state_i[1] : ~touch_i[0];
            assign state_o[2] = touch_i[1] ? ~touch_i[0] : state_i[2];
        end else if (WAYS == 2) begin : g_two
            assign victim_o = state_i;
            assign state_o  = ~touch_i;
        end else begin : g_one
            logic unused_touch;
            assign unused_touch = ^touch_i;
            assign victim_o     = '0;
            assign state_o      = state_i;
        end
    endgenerate

endmodule

// File: rtl/bpred_btb.sv
// rtl/bpred_btb.sv - set-associative branch target buffer with PLRU replacement
// Combinational lookup on pc_if; one resolved-branch update per cycle from EX.
module bpred_btb
    import btb_pkg::*;
#(
    parameter int BTB_INDEX = DEF_BTB_INDEX,
    parameter int WAYS      = 2,
    parameter int IDX_LSB   = DEF_IDX_LSB,
    parameter int CTR_BITS  = DEF_CTR_BITS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_if,
    output logic        hit,
    output logic        predict_taken,
    output logic [31:0] predicted_pc,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_is_jump,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        flush_all
);

    localparam int SETS  = 1 << BTB_INDEX;
    localparam int TAG_W = 32 - IDX_LSB - BTB_INDEX;
    localparam int WW    = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int PW    = (WAYS > 1) ? WAYS - 1 : 1;

    btb_entry_t entry_q [SETS][WAYS];

    logic [BTB_INDEX-1:0] if_idx, upd_idx;
    logic [TAG_W-1:0]     if_tag, upd_tag;
    logic [WAYS-1:0]      if_match, upd_match, upd_invalid;
    logic [WW-1:0]        if_way, upd_way, free_way, victim_way;
    btb_entry_t           upd_entry;
    logic                 if_ctr_msb;
    logic [29:0]          if_target;

    // Ways are scanned downward so the lowest-numbered match or free way wins.
    always_comb begin
        if_idx      = pc_if[IDX_LSB +: BTB_INDEX];
        if_tag      = pc_if[31 -: TAG_W];
        upd_idx     = upd_pc[IDX_LSB +: BTB_INDEX];
        upd_tag     = upd_pc[31 -: TAG_W];
        if_match    = '0;
        upd_match   = '0;
        upd_invalid = '0;
        if_way      = '0;
        upd_way     = '0;
        free_way    = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if_match[w]    = entry_q[if_idx][w].valid && (entry_q[if_idx][w].tag == if_tag);
            upd_match[w]   = entry_q[upd_idx][w].valid && (entry_q[upd_idx][w].tag == upd_tag);
            upd_invalid[w] = !entry_q[upd_idx][w].valid;
            if (if_match[w]) if_way = WW'(w);
            if (upd_match[w]) upd_way = WW'(w);
            if (upd_invalid[w]) free_way = WW'(w);
        end
        if_ctr_msb = entry_q[if_idx][if_way].ctr[CTR_BITS-1];
        if_target  = entry_q[if_idx][if_way].target;
        upd_entry  = entry_q[upd_idx][upd_way];
    end

    assign hit           = |if_match;
    assign predict_taken = hit && if_ctr_msb;
    assign predicted_pc  = predict_taken ? {if_target, 2'b00} : pc_if + 32'd4;

    logic       wr_en_d;
    logic [WW-1:0] wr_way_d;
    btb_entry_t wr_entry_d;

    always_comb begin
        wr_en_d    = 1'b0;
        wr_way_d   = upd_way;
        wr_entry_d = upd_entry;
        if (upd_valid) begin
            if (|upd_match) begin
                wr_en_d = 1'b1;
                if (upd_is_jump) begin
                    wr_entry_d.ctr    = CTR_STRONG_TAKEN;
                    wr_entry_d.target = upd_target[31:2];
                end else begin
                    wr_entry_d.ctr = sat_ctr_next(upd_entry.ctr, upd_taken);
                    if (upd_taken) wr_entry_d.target = upd_target[31:2];
                end
            end else if (upd_taken) begin
                wr_en_d           = 1'b1;
                wr_way_d          = (|upd_invalid) ? free_way : victim_way;
                wr_entry_d.valid  = 1'b1;
                wr_entry_d.tag    = upd_tag;
                wr_entry_d.target = upd_target[31:2];
                wr_entry_d.ctr    = upd_is_jump ? CTR_STRONG_TAKEN : CTR_WEAK_TAKEN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    entry_q[s][w] <= '0;
                end
            end
        end else if (flush_all) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    entry_q[s][w].valid <= 1'b0;
                end
            end
        end else if (wr_en_d) begin
            entry_q[upd_idx][wr_way_d] <= wr_entry_d;
        end
    end

    generate
        if (WAYS > 1) begin : g_plru
            logic [PW-1:0] plru_q [SETS];
            logic [PW-1:0] plru_next;

            plru_tree #(.WAYS(WAYS)) u_plru (
                .state_i  (plru_q[upd_idx]),
                .touch_i  (wr_way_d),
                .victim_o (victim_way),
                .state_o  (plru_next)
            );

            // Only EX updates move PLRU; lookups leave it alone.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int s = 0; s < SETS; s++) begin
                        plru_q[s] <= '0;
                    end
                end else if (!flush_all && wr_en_d) begin
                    plru_q[upd_idx] <= plru_next;
                end
            end
        end else begin : g_no_plru
            assign victim_way = '0;
        end
    endgenerate

    logic unused_bits;
    assign unused_bits = ^{upd_pc[IDX_LSB-1:0], upd_target[1:0]};

    a_if_single_match: assert property (@(posedge clk) disable iff (rst) $onehot0(if_match));
    a_upd_single_match: assert property (@(posedge clk) disable iff (rst) $onehot0(upd_match));

endmodule

// File: tb/tb_bpred_btb.sv
// tb/tb_bpred_btb.sv - self-checking bench for bpred_btb against an LRU-timestamp model
module tb_bpred_btb;

    localparam int SETS = 16;
    localparam int NW   = 2;

    logic        clk = 1'b0;
    logic        rst, upd_valid, upd_is_jump, upd_taken, flush_all;
    logic [31:0] pc_if, upd_pc, upd_target, predicted_pc;
    logic        hit, predict_taken;

    always #5 clk = ~clk;

    bpred_btb dut (
        .clk           (clk),
        .rst           (rst),
        .pc_if         (pc_if),
        .hit           (hit),
        .predict_taken (predict_taken),
        .predicted_pc  (predicted_pc),
        .upd_valid     (upd_valid),
        .upd_pc        (upd_pc),
        .upd_is_jump   (upd_is_jump),
        .upd_taken     (upd_taken),
        .upd_target    (upd_target),
        .flush_all     (flush_all)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: each set holds NW entries; replacement evicts the way touched longest ago.
    bit          m_valid [SETS][NW];
    logic [25:0] m_tag   [SETS][NW];
    logic [31:0] m_tgt   [SETS][NW];
    int          m_ctr   [SETS][NW];
    int          m_age   [SETS][NW];
    int          now = 0;

    function automatic int m_find(input logic [31:0] pc);
        for (int w = 0; w < NW; w++) begin
            if (m_valid[pc[5:2]][w] && m_tag[pc[5:2]][w] == pc[31:6]) return w;
        end
        return -1;
    endfunction

    function automatic logic [33:0] m_lookup(input logic [31:0] pc);
        int  w;
        bit  t;
        w = m_find(pc);
        if (w < 0) return {1'b0, 1'b0, pc + 32'd4};
        t = (m_ctr[pc[5:2]][w] >= 2);
        return {1'b1, t, t ? m_tgt[pc[5:2]][w] : pc + 32'd4};
    endfunction

    task automatic m_apply();
        int s, w;
        now++;
        if (rst) begin
            for (int i = 0; i < SETS; i++)
                for (int j = 0; j < NW; j++) begin
                    m_valid[i][j] = 0; m_ctr[i][j] = 0; m_age[i][j] = 0;
                end
        end else if (flush_all) begin
            for (int i = 0; i < SETS; i++)
                for (int j = 0; j < NW; j++) m_valid[i][j] = 0;
        end else if (upd_valid) begin
            s = upd_pc[5:2];
            w = m_find(upd_pc);
            if (w >= 0) begin
                if (upd_is_jump) begin
                    m_ctr[s][w] = 3;
                    m_tgt[s][w] = upd_target & 32'hFFFF_FFFC;
                end else begin
                    m_ctr[s][w] = upd_taken ? ((m_ctr[s][w] < 3) ? m_ctr[s][w] + 1 : 3)
                                            : ((m_ctr[s][w] > 0) ? m_ctr[s][w] - 1 : 0);
                    if (upd_taken) m_tgt[s][w] = upd_target & 32'hFFFF_FFFC;
                end
                m_age[s][w] = now;
            end else if (upd_taken) begin
                for (int j = NW - 1; j >= 0; j--) if (!m_valid[s][j]) w = j;
                if (w < 0) begin
                    w = 0;
                    for (int j = 1; j < NW; j++) if (m_age[s][j] < m_age[s][w]) w = j;
                end
                m_valid[s][w] = 1;
                m_tag[s][w]   = upd_pc[31:6];
                m_tgt[s][w]   = upd_target & 32'hFFFF_FFFC;
                m_ctr[s][w]   = upd_is_jump ? 3 : 2;
                m_age[s][w]   = now;
            end
        end
    endtask

    task automatic step();
        m_apply();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rst = 0; upd_valid = 0; upd_pc = 0; upd_is_jump = 0; upd_taken = 0;
        upd_target = 0; flush_all = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        step();
        rst = 0;
    endtask

    task automatic upd(input logic [31:0] pc, input logic j, input logic t, input logic [31:0] tg);
        upd_valid = 1; upd_pc = pc; upd_is_jump = j; upd_taken = t; upd_target = tg;
        step();
        upd_valid = 0;
    endtask

    task automatic test_reset();
        do_reset();
        pc_if = 32'h100; #1; checks++;
        if ({hit, predict_taken, predicted_pc} !== {1'b0, 1'b0, 32'h104}) begin
            errors++; $display("FAIL reset_0x100: got %b/%b/%h expected 0/0/00000104", hit, predict_taken, predicted_pc);
        end
        pc_if = 32'h0; #1; checks++;
        if ({hit, predict_taken, predicted_pc} !== {1'b0, 1'b0, 32'h4}) begin
            errors++; $display("FAIL reset_0x0: got %b/%b/%h expected 0/0/00000004", hit, predict_taken, predicted_pc);
        end
    endtask

    task automatic test_alloc_and_counter();
        do_reset();
        upd(32'h100, 0, 1, 32'h200);
        pc_if = 32'h100; #1; checks++;
        if ({hit, predict_taken, predicted_pc} !== {1'b1, 1'b1, 32'h200}) begin
            errors++; $display("FAIL alloc_hit: got %b/%b/%h expected 1/1/00000200", hit, predict_taken, predicted_pc);
        end
        pc_if = 32'h140; #1; checks++;
        if ({hit, predict_taken, predicted_pc} !== {1'b0, 1'b0, 32'h144}) begin
            errors++; $display("FAIL alloc_other_tag: got %b/%b/%h expected 0/0/00000144", hit, predict_taken, predicted_pc);
        end
        upd(32'h100, 0, 0, 32'h0);
        pc_if = 32'h100; #1; checks++;
        if ({hit, predict_taken, predicted_pc} !== {1'b1, 1'b0, 32'h104}) begin
            errors++; $display("FAIL ctr_01: got %b/%b/%h expected 1/0/00000104", hit, predict_taken, predicted_pc);
        end
        upd(32'h100, 0, 0, 32'h0);
        #1; checks++;
        if ({hit, predict_taken, predicted_pc} !== {1'b1, 1'b0, 32'h104}) begin
            errors++; $display("FAIL ctr_00: got %b/%b/%h expected 1/0/00000104", hit, predict_taken, predicted_pc);
        end
        upd(32'h100, 0, 1, 32'h220);
        upd(32'h100, 0, 1, 32'h220);
        #1; checks++;
        if ({hit, predict_taken, predicted_pc} !== {1'b1, 1'b1, 32'h220}) begin
            errors++; $display("FAIL ctr_10_retarget: got %b/%b/%h expected 1/1/00000220", hit, predict_taken, predicted_pc);
        end
        upd(32'h100, 0, 1, 32'h220);
        upd(32'h100, 0, 1, 32'h220);
        upd(32'h100, 0, 0, 32'h888);
        #1; checks++;
        if ({hit, predict_taken, predicted_pc} !== {1'b1, 1'b1, 32'h220}) begin
            errors++; $display("FAIL ctr_saturate: got %b/%b/%h expected 1/1/00000220", hit, predict_taken, predicted_pc);
        end
        upd(32'h100, 0, 0, 32'h888);
        #1; checks++;
        if ({hit, predict_taken, predicted_pc} !== {1'b1, 1'b0, 32'h104}) begin
            errors++; $display("FAIL ctr_down_from_sat: got %b/%b/%h expected 1/0/00000104", hit, predict_taken, predicted_pc);
        end
    endtask

    task automatic test_replacement();
        do_reset();
        upd(32'h100, 0, 1, 32'h200);
        upd(32'h140, 0, 1, 32'h300);
        upd(32'h180, 0, 1, 32'h400);
        pc_if = 32'h100; #1; checks++;
        if ({hit, predict_taken, predicted_pc} !== {1'b0, 1'b0, 32'h104}) begin
            errors++; $display("FAIL evict_0x100: got %b/%b/%h expected 0/0/00000104", hit, predict_taken, predicted_pc);
        end
        pc_if = 32'h140; #1; checks++;
        if ({hit, predict_taken, predicted_pc} !== {1'b1, 1'b1, 32'h300}) begin
            errors++; $display("FAIL keep_0x140: got %b/%b/%h expected 1/1/00000300", hit, predict_taken, predicted_pc);
        end
        pc_if = 32'h180; #1; checks++;
        if ({hit, predict_taken, predicted_pc} !== {1'b1, 1'b1, 32'h400}) begin
            errors++; $display("FAIL new_0x180: got %b/%b/%h expected 1/1/00000400", hit, predict_taken, predicted_pc);
        end
        upd(32'h140, 0, 1, 32'h300);
        upd(32'h1C0, 0, 1, 32'h500);
        pc_if = 32'h180; #1; checks++;
        if ({hit, predict_taken, predicted_pc} !== {1'b0, 1'b0, 32'h184}) begin
            errors++; $display("FAIL touch_evict_0x180: got %b/%b/%h expected 0/0/00000184", hit, predict_taken, predicted_pc);
        end
        pc_if = 32'h140; #1; checks++;
        if ({hit, predict_taken, predicted_pc} !== {1'b1, 1'b1, 32'h300}) begin
            errors++; $display("FAIL touch_keep_0x140: got %b/%b/%h expected 1/1/00000300", hit, predict_taken, predicted_pc);
        end
    endtask

    task automatic test_no_alloc_and_jump();
        do_reset();
        upd(32'h500, 0, 0, 32'h600);
        pc_if = 32'h500; #1; checks++;
        if ({hit, predict_taken, predicted_pc} !== {1'b0, 1'b0, 32'h504}) begin
            errors++; $display("FAIL not_taken_no_alloc: got %b/%b/%h expected 0/0/00000504", hit, predict_taken, predicted_pc);
        end
        upd(32'h500, 1, 1, 32'h603);
        #1; checks++;
        if ({hit, predict_taken, predicted_pc} !== {1'b1, 1'b1, 32'h600}) begin
            errors++; $display("FAIL jump_alloc: got %b/%b/%h expected 1/1/00000600", hit, predict_taken, predicted_pc);
        end
        upd(32'h500, 0, 0, 32'h0);
        #1; checks++;
        if ({hit, predict_taken, predicted_pc} !== {1'b1, 1'b1, 32'h600}) begin
            errors++; $display("FAIL jump_ctr_strong: got %b/%b/%h expected 1/1/00000600", hit, predict_taken, predicted_pc);
        end
    endtask

    task automatic test_same_cycle_flush_rst();
        do_reset();
        upd(32'h100, 0, 1, 32'h200);
        upd_valid = 1; upd_pc = 32'h100; upd_is_jump = 0; upd_taken = 0; pc_if = 32'h100;
        #1; checks++;
        if ({hit, predict_taken, predicted_pc} !== {1'b1, 1'b1, 32'h200}) begin
            errors++; $display("FAIL same_cycle_old: got %b/%b/%h expected 1/1/00000200", hit, predict_taken, predicted_pc);
        end
        step();
        upd_valid = 0; #1; checks++;
        if ({hit, predict_taken, predicted_pc} !== {1'b1, 1'b0, 32'h104}) begin
            errors++; $display("FAIL same_cycle_new: got %b/%b/%h expected 1/0/00000104", hit, predict_taken, predicted_pc);
        end
        upd(32'h140, 0, 1, 32'h300);
        flush_all = 1; upd_valid = 1; upd_pc = 32'h180; upd_taken = 1; upd_target = 32'h400;
        step();
        clear_inputs();
        for (int i = 0; i < 3; i++) begin
            pc_if = 32'h100 + 32'(i) * 32'h40; #1; checks++;
            if (hit !== 1'b0 || predict_taken !== 1'b0) begin
                errors++; $display("FAIL flush_miss: pc %h got hit %b pt %b expected 0/0", pc_if, hit, predict_taken);
            end
        end
        upd(32'h100, 1, 1, 32'h200);
        upd(32'h140, 0, 1, 32'h300);
        rst = 1; upd_valid = 1; upd_pc = 32'h180; upd_taken = 1; upd_target = 32'h400;
        step();
        clear_inputs();
        for (int i = 0; i < 3; i++) begin
            pc_if = 32'h100 + 32'(i) * 32'h40; #1; checks++;
            if ({hit, predict_taken, predicted_pc} !== {1'b0, 1'b0, pc_if + 32'd4}) begin
                errors++; $display("FAIL rst_miss: pc %h got %b/%b/%h expected 0/0/%h", pc_if, hit, predict_taken, predicted_pc, pc_if + 32'd4);
            end
        end
    endtask

    task automatic test_random();
        logic [33:0] exp;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            pc_if       = {24'($urandom_range(0, 3)), 2'b00, 4'($urandom_range(0, 3)), 2'b00};
            upd_valid   = ($urandom_range(0, 3) != 0);
            upd_pc      = {24'($urandom_range(0, 3)), 2'b00, 4'($urandom_range(0, 3)), 2'b00};
            upd_is_jump = ($urandom_range(0, 3) == 0);
            upd_taken   = $urandom_range(0, 1) != 0;
            upd_target  = $urandom;
            flush_all   = ($urandom_range(0, 60) == 0);
            rst         = ($urandom_range(0, 120) == 0);
            #1;
            exp = m_lookup(pc_if);
            checks++;
            if ({hit, predict_taken, predicted_pc} !== exp) begin
                errors++;
                $display("FAIL random_lookup[%0d]: pc %h got %b/%b/%h expected %b/%b/%h", i, pc_if,
                         hit, predict_taken, predicted_pc, exp[33], exp[32], exp[31:0]);
            end
            step();
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        pc_if = 0;
        test_reset();
        test_alloc_and_counter();
        test_replacement();
        test_no_alloc_and_jump();
        test_same_cycle_flush_rst();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
